// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: RV32I load/store funct3 encodings and LSU state/timeout defaults.
package cpu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int unsigned LSU_TIMEOUT = 256;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, load extraction/extension
// and misalignment / illegal-funct3 detection.
module lsu_align
    import cpu_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_rep_o,
    output logic [31:0] rdata_ext_o,
    output logic        misalign_o,
    output logic        illegal_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        misalign_o = 1'b0;
        if (funct3_i[1:0] == 2'b01)
            misalign_o = addr_lo_i[0];
        else if (funct3_i[1:0] == 2'b10)
            misalign_o = (addr_lo_i != 2'b00);

        if (we_i)
            illegal_o = (funct3_i > F3_SW);
        else
            illegal_o = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
    end

    always_comb begin
        be_o        = 4'hF;
        wdata_rep_o = wdata_i;
        if (we_i) begin
            case (funct3_i)
                F3_SB: begin
                    be_o        = 4'b0001 << addr_lo_i;
                    wdata_rep_o = {4{wdata_i[7:0]}};
                end
                F3_SH: begin
                    be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    wdata_rep_o = {2{wdata_i[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (funct3_i)
            F3_LB:   rdata_ext_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  rdata_ext_o = {24'd0, byte_sel};
            F3_LH:   rdata_ext_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  rdata_ext_o = {16'd0, half_sel};
            F3_LW:   rdata_ext_o = rdata_i;
            default: rdata_ext_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives a request/grant/response memory port, stalls the
// pipeline while an access is outstanding and returns one completion pulse per access.
module mem_stage_lsu
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT,
    parameter int unsigned CNT_W          = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        lsu_stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  alo_q, alo_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        idle, timeout, bad;
    logic        a_we, a_misalign, a_illegal;
    logic [2:0]  a_f3;
    logic [1:0]  a_alo;
    logic [3:0]  a_be;
    logic [31:0] a_wdata, a_rdata;

    // In IDLE the aligner looks at the live request; afterwards at the latched copy.
    assign idle  = (state_q == LSU_IDLE);
    assign a_we  = idle ? req_we : we_q;
    assign a_f3  = idle ? req_funct3 : f3_q;
    assign a_alo = idle ? req_addr[1:0] : alo_q;

    lsu_align u_align (
        .we_i        (a_we),
        .funct3_i    (a_f3),
        .addr_lo_i   (a_alo),
        .wdata_i     (req_wdata),
        .rdata_i     (mem_rdata),
        .be_o        (a_be),
        .wdata_rep_o (a_wdata),
        .rdata_ext_o (a_rdata),
        .misalign_o  (a_misalign),
        .illegal_o   (a_illegal)
    );

    assign bad     = a_misalign | a_illegal;
    assign timeout = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

    assign lsu_stall = (idle & req_valid) | (state_q == LSU_REQ) | (state_q == LSU_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LSU_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: if (req_valid) state_d = bad ? LSU_RESP : LSU_REQ;
            LSU_REQ: begin
                if (mem_gnt)      state_d = we_q ? LSU_RESP : LSU_WAIT;
                else if (timeout) state_d = LSU_RESP;
            end
            LSU_WAIT: if (mem_rvalid || timeout) state_d = LSU_RESP;
            LSU_RESP: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // Next values of every registered output; completion takes priority over timeout.
    always_comb begin
        cnt_d       = cnt_q;
        we_d        = we_q;
        f3_d        = f3_q;
        alo_d       = alo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    we_d  = req_we;
                    f3_d  = req_funct3;
                    alo_d = req_addr[1:0];
                    if (bad) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_be_d    = a_be;
                        mem_wdata_d = a_wdata;
                    end
                end
            end
            LSU_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_gnt || timeout) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
                if (mem_gnt) begin
                    rsp_valid_d = we_q;
                end else if (timeout) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            LSU_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_rvalid) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = a_rdata;
                end else if (timeout) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            we_q        <= 1'b0;
            f3_q        <= '0;
            alo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            alo_q       <= alo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
